// File: rtl/alu_mul_seq.sv
// Sequential shift-add unsigned multiplier that borrows the shared 32-bit ALU as its adder,
// issuing one add per clock for a fixed WIDTH-step latency.
module alu_mul_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0] mplier_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [31:0]      product_o,
    output logic             zero_o,
    output logic [31:0]      alu_src1_o,
    output logic [31:0]      alu_src2_o,
    output logic [3:0]       alu_ctrl_o,
    input  logic [31:0]      alu_result_i,
    input  logic             alu_zero_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0010;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [31:0]      product_q, product_d;
    logic             zero_q, zero_d;
    logic             last_step;

    assign last_step = (step_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        product_d = product_q;
        zero_d    = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_RUN;
                    mcand_d  = {{(32 - WIDTH){1'b0}}, mcand_i};
                    mplier_d = mplier_i;
                    acc_d    = '0;
                    step_d   = '0;
                end
            end
            S_RUN: begin
                acc_d  = alu_result_i;
                step_d = step_q + CNT_W'(1);
                // The final ALU sum is also the product; publish it on the same edge.
                if (last_step) begin
                    state_d   = S_DONE;
                    product_d = alu_result_i;
                    zero_d    = alu_zero_i;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outside RUN the ALU sees AND of zeros so it stays quiet for other users.
    always_comb begin
        alu_ctrl_o = ALU_AND;
        alu_src1_o = '0;
        alu_src2_o = '0;
        if (state_q == S_RUN) begin
            alu_ctrl_o = ALU_ADD;
            alu_src1_o = acc_q;
            alu_src2_o = mplier_q[step_q] ? (mcand_q << step_q) : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            zero_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
            zero_q    <= zero_d;
        end
    end

    assign busy_o    = (state_q == S_RUN);
    assign done_o    = (state_q == S_DONE);
    assign product_o = product_q;
    assign zero_o    = zero_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: drives it against a behavioural ALU and compares each result
// with the arithmetic product of the operands.
module tb_alu_mul_seq;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [15:0] mcand_i, mplier_i;
    logic        busy_o, done_o, zero_o;
    logic [31:0] product_o, alu_src1_o, alu_src2_o, alu_result_i;
    logic [3:0]  alu_ctrl_o;
    logic        alu_zero_i;

    int checks = 0;
    int errors = 0;
    int accepted = 0;
    int done_seen = 0;
    logic [31:0] last_prod;

    alu_mul_seq #(.WIDTH(16), .CNT_W(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .mcand_i(mcand_i), .mplier_i(mplier_i),
        .busy_o(busy_o), .done_o(done_o),
        .product_o(product_o), .zero_o(zero_o),
        .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o), .alu_ctrl_o(alu_ctrl_o),
        .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i)
    );

    always #5 clk_i = ~clk_i;

    // Shared ALU: add and and are the only operations this block uses.
    always_comb begin
        case (alu_ctrl_o)
            4'b0010: alu_result_i = alu_src1_o + alu_src2_o;
            4'b0000: alu_result_i = alu_src1_o & alu_src2_o;
            default: alu_result_i = 32'hDEAD_BEEF;
        endcase
        alu_zero_i = (alu_result_i == 32'd0);
    end

    always @(negedge clk_i) if (done_o) done_seen++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one multiply from IDLE and checks timing and result; optional spurious starts.
    task automatic run_op(input logic [15:0] mc, input logic [15:0] mp,
                          input bit ign_run, input bit ign_done, input bit check_ctrl);
        logic [31:0] exp_p;
        int cnt;
        int busy_cnt;
        bit ctrl_ok;
        exp_p = 32'(mc) * 32'(mp);
        mcand_i  = mc;
        mplier_i = mp;
        start_i  = 1'b1;
        @(posedge clk_i);
        accepted++;
        @(negedge clk_i);
        start_i  = 1'b0;
        cnt      = 1;
        busy_cnt = 0;
        ctrl_ok  = 1'b1;
        while (!done_o && cnt < 40) begin
            if (busy_o) begin
                busy_cnt++;
                if (alu_ctrl_o !== 4'b0010) ctrl_ok = 1'b0;
                if (product_o !== last_prod) ctrl_ok = 1'b0;
            end
            if (ign_run && cnt == 5) begin
                mcand_i = 16'd7; mplier_i = 16'd9; start_i = 1'b1;
            end
            if (ign_run && cnt == 6) start_i = 1'b0;
            @(negedge clk_i);
            cnt++;
        end
        check("latency", 32'(cnt), 32'd17);
        check("busy_cycles", 32'(busy_cnt), 32'd16);
        if (check_ctrl) check("run_ctrl_and_hold", 32'(ctrl_ok), 32'd1);
        check("busy_in_done", 32'(busy_o), 32'd0);
        check("product", product_o, exp_p);
        check("zero", 32'(zero_o), 32'(exp_p == 32'd0));
        if (ign_done) begin
            mcand_i = 16'd7; mplier_i = 16'd9; start_i = 1'b1;
        end
        @(negedge clk_i);
        start_i = 1'b0;
        check("idle_after_done", {30'd0, busy_o, done_o}, 32'd0);
        check("product_held", product_o, exp_p);
        last_prod = exp_p;
    endtask

    initial begin
        rst_i = 1'b0; start_i = 1'b0; mcand_i = '0; mplier_i = '0;
        last_prod = 32'd0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (5) @(negedge clk_i);
        check("rst_product", product_o, 32'd0);
        check("rst_zero", 32'(zero_o), 32'd1);
        check("rst_busy_done", {30'd0, busy_o, done_o}, 32'd0);
        check("rst_ctrl", 32'(alu_ctrl_o), 32'd0);

        run_op(16'd3, 16'd5, 1'b0, 1'b0, 1'b1);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1);
        run_op(16'h1234, 16'd0, 1'b0, 1'b0, 1'b1);
        run_op(16'd3, 16'd5, 1'b1, 1'b1, 1'b1);
        run_op(16'd7, 16'd9, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a run, at step 8.
        mcand_i = 16'h00FF; mplier_i = 16'h0F0F; start_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (8) @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        check("arst_busy_done", {30'd0, busy_o, done_o}, 32'd0);
        check("arst_product", product_o, 32'd0);
        check("arst_zero", 32'(zero_o), 32'd1);
        check("arst_alu", {28'd0, alu_ctrl_o} | alu_src1_o | alu_src2_o, 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        last_prod = 32'd0;
        @(negedge clk_i);
        run_op(16'd2, 16'd2, 1'b0, 1'b0, 1'b1);

        // Random operands with random idle gaps.
        accepted  = 0;
        done_seen = 0;
        for (int n = 0; n < 1000; n++) begin
            logic [15:0] a, b;
            case ($urandom_range(0, 3))
                0:       begin a = 16'($urandom); b = 16'($urandom); end
                1:       begin a = 16'($urandom_range(0, 15)); b = 16'($urandom); end
                2:       begin a = 16'($urandom); b = 16'($urandom_range(0, 3)); end
                default: begin a = 16'hFFFF - 16'($urandom_range(0, 7)); b = 16'($urandom); end
            endcase
            run_op(a, b, 1'b0, 1'b0, 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
        end
        check("done_count", 32'(done_seen), 32'(accepted));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
